// File: rtl/alpaca_ospfb_constants_pkg.sv
// Shared constants and types for the ALPACA OSPFB test-stream blocks.
//   WIDTH       : default sample width of the impulse stream
//   PERIOD      : default frame length in beats (FFT length)
//   chk_state_t : impulse checker lock state
//   chk_err_t   : impulse checker error classification (err_code encoding)
package alpaca_ospfb_constants_pkg;

    localparam int WIDTH  = 16;
    localparam int PERIOD = 64;

    typedef enum logic {
        SEARCH,
        LOCKED
    } chk_state_t;

    typedef enum logic [1:0] {
        ERR_NONE  = 2'd0,
        ERR_PHASE = 2'd1,
        ERR_MISS  = 2'd2,
        ERR_VALUE = 2'd3
    } chk_err_t;

endpackage

// File: rtl/axis.sv
// Minimal AXI-Stream bundle (tdata, tvalid, tready).
//   MST : drives tdata/tvalid, observes tready
//   SLV : observes tdata/tvalid, drives tready
interface axis #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] tdata;
    logic             tvalid;
    logic             tready;

    modport MST (output tdata, output tvalid, input  tready);
    modport SLV (input  tdata, input  tvalid, output tready);
endinterface

// File: rtl/chk_ready_gen.sv
// Registered tready generator for stream sinks, with an optional periodic
// single-cycle stall so that upstream backpressure handling gets exercised.
//   clk, rst : clock, asynchronous active-low reset
//   en       : permits ready assertion
//   ready    : registered tready; low one cycle in every STALL_EVERY cycles
//              when STALL_EVERY > 1, otherwise simply follows en
// The stall counter runs free and is not affected by any sink-level clear,
// so the stall cadence stays periodic across checker clears.
module chk_ready_gen #(
    parameter int STALL_EVERY = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic ready
);

    localparam int CW = (STALL_EVERY > 1) ? $clog2(STALL_EVERY) : 1;
    localparam logic [CW-1:0] LAST = CW'((STALL_EVERY > 1) ? STALL_EVERY - 1 : 0);

    logic [CW-1:0] stall_ctr;
    logic          stall_now;

    assign stall_now = (STALL_EVERY > 1) && (stall_ctr == LAST);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_ctr <= '0;
            ready     <= 1'b0;
        end else begin
            ready <= en && !stall_now;
            if (STALL_EVERY <= 1 || stall_ctr == LAST) stall_ctr <= '0;
            else                                        stall_ctr <= stall_ctr + 1'b1;
        end
    end

endmodule

// File: rtl/impulse_checker.sv
// AXI-Stream sink for the periodic test-impulse stream. Tracks the stream
// position modulo MAX_CNT, locks onto the impulse phase and verifies exactly
// one impulse of weight EXP_VAL per frame.
//   clk, rst   : clock, asynchronous active-low reset
//   s_axis     : stream input (tdata/tvalid in, tready out)
//   en         : permits tready assertion
//   clr        : synchronous clear of counters, FSM and position
//   locked     : FSM is in LOCKED
//   lock_phase : frame position of the locked impulse
//   phase_ok   : locked at IMPULSE_PHASE
//   frame_cnt  : frames with a correct impulse (saturating)
//   err_cnt    : errors detected (saturating)
//   err_pulse  : one-cycle strobe per error
//   err_code   : last error (chk_err_t encoding), held until reset/clr
module impulse_checker #(
    parameter int WIDTH         = alpaca_ospfb_constants_pkg::WIDTH,
    parameter int MAX_CNT       = alpaca_ospfb_constants_pkg::PERIOD,
    parameter int IMPULSE_PHASE = 49,
    parameter int EXP_VAL       = 1,
    parameter int STALL_EVERY   = 0,
    parameter int CNT_W         = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    axis.SLV                           s_axis,
    input  logic                       en,
    input  logic                       clr,
    output logic                       locked,
    output logic [$clog2(MAX_CNT)-1:0] lock_phase,
    output logic                       phase_ok,
    output logic [CNT_W-1:0]           frame_cnt,
    output logic [CNT_W-1:0]           err_cnt,
    output logic                       err_pulse,
    output logic [1:0]                 err_code
);

    import alpaca_ospfb_constants_pkg::*;

    localparam int                PW      = $clog2(MAX_CNT);
    localparam logic [WIDTH-1:0]  EXP     = WIDTH'(EXP_VAL);
    localparam logic [PW-1:0]     EXP_PH  = PW'(IMPULSE_PHASE);
    localparam logic [CNT_W-1:0]  CNT_TOP = '1;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_TOP) ? v : v + 1'b1;
    endfunction

    logic tready;

    chk_ready_gen #(.STALL_EVERY(STALL_EVERY)) u_ready (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .ready (tready)
    );

    assign s_axis.tready = tready;

    logic beat, hit;
    assign beat = s_axis.tvalid && tready;
    assign hit  = beat && (s_axis.tdata != '0);

    chk_state_t       state, state_n;
    chk_err_t         code_q, code_n, err_kind;
    logic [PW-1:0]    pos, pos_n, phase_n;
    logic [CNT_W-1:0] fcnt_n, ecnt_n;
    logic             pulse_n;

    // NOTE: every signal assigned in this block gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_n  = state;
        pos_n    = pos;
        phase_n  = lock_phase;
        fcnt_n   = frame_cnt;
        ecnt_n   = err_cnt;
        code_n   = code_q;
        pulse_n  = 1'b0;
        err_kind = ERR_NONE;

        // MAX_CNT is a power of two, so the natural wrap of pos is the frame wrap.
        if (beat) pos_n = pos + 1'b1;

        unique case (state)
            SEARCH: begin
                if (hit) begin
                    phase_n = pos;
                    state_n = LOCKED;
                    if (s_axis.tdata != EXP) err_kind = ERR_VALUE;
                end
            end
            LOCKED: begin
                if (beat && pos == lock_phase) begin
                    if (s_axis.tdata == EXP)      fcnt_n = sat_inc(frame_cnt);
                    else if (s_axis.tdata == '0) begin
                        err_kind = ERR_MISS;
                        state_n  = SEARCH;
                    end else                      err_kind = ERR_VALUE;
                end else if (hit) begin
                    // Impulse moved: follow it so later frames are judged at the new phase.
                    err_kind = ERR_PHASE;
                    phase_n  = pos;
                end
            end
            default: state_n = SEARCH;
        endcase

        if (err_kind != ERR_NONE) begin
            code_n  = err_kind;
            pulse_n = 1'b1;
            ecnt_n  = sat_inc(err_cnt);
        end

        // Clear overrides everything, including a coincident beat.
        if (clr) begin
            state_n = SEARCH;
            pos_n   = '0;
            phase_n = '0;
            fcnt_n  = '0;
            ecnt_n  = '0;
            code_n  = ERR_NONE;
            pulse_n = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= SEARCH;
            pos        <= '0;
            lock_phase <= '0;
            frame_cnt  <= '0;
            err_cnt    <= '0;
            code_q     <= ERR_NONE;
            err_pulse  <= 1'b0;
        end else begin
            state      <= state_n;
            pos        <= pos_n;
            lock_phase <= phase_n;
            frame_cnt  <= fcnt_n;
            err_cnt    <= ecnt_n;
            code_q     <= code_n;
            err_pulse  <= pulse_n;
        end
    end

    assign locked   = (state == LOCKED);
    assign phase_ok = locked && (lock_phase == EXP_PH);
    assign err_code = code_q;

endmodule

// File: tb/tb_impulse_checker.sv
// Self-checking bench for impulse_checker: a randomized AXI-Stream impulse
// source (random tvalid gaps) drives the DUT, and a beat-level reference
// model derived from the checker rules predicts every status output each
// cycle. Directed scenario checks compare against hand-derived constants.
module tb_impulse_checker;

    localparam int W     = 16;
    localparam int M     = 64;
    localparam int PH    = 49;
    localparam int EXPV  = 1;
    localparam int S     = 5;
    localparam int CW    = 4;
    localparam int CMAX  = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic          clr;
    logic          locked;
    logic [5:0]    lock_phase;
    logic          phase_ok;
    logic [CW-1:0] frame_cnt;
    logic [CW-1:0] err_cnt;
    logic          err_pulse;
    logic [1:0]    err_code;

    axis #(.WIDTH(W)) s_axis_if ();

    impulse_checker #(
        .WIDTH(W), .MAX_CNT(M), .IMPULSE_PHASE(PH), .EXP_VAL(EXPV),
        .STALL_EVERY(S), .CNT_W(CW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .s_axis     (s_axis_if),
        .en         (en),
        .clr        (clr),
        .locked     (locked),
        .lock_phase (lock_phase),
        .phase_ok   (phase_ok),
        .frame_cnt  (frame_cnt),
        .err_cnt    (err_cnt),
        .err_pulse  (err_pulse),
        .err_code   (err_code)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    // Reference model state (plain integers, beat-level semantics)
    int m_pos, m_locked, m_phase, m_fc, m_ec, m_pulse, m_code, m_tready, m_stall;
    // Impulse source state
    int src_ctr, src_frames, src_phase, src_val, src_suppress;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_pos = 0; m_locked = 0; m_phase = 0; m_fc = 0; m_ec = 0;
        m_pulse = 0; m_code = 0;
    endtask

    task automatic model_step(input bit c, input bit b, input int d);
        int p, err;
        m_pulse = 0;
        if (c) begin
            model_reset();
            return;
        end
        if (!b) return;
        p = m_pos;
        m_pos = (m_pos + 1) % M;
        err = 0;
        if (!m_locked) begin
            if (d != 0) begin
                m_locked = 1;
                m_phase  = p;
                if (d != EXPV) err = 3;
            end
        end else if (p == m_phase) begin
            if (d == EXPV)   m_fc = (m_fc < CMAX) ? m_fc + 1 : CMAX;
            else if (d == 0) begin err = 2; m_locked = 0; end
            else             err = 3;
        end else if (d != 0) begin
            err = 1;
            m_phase = p;
        end
        if (err != 0) begin
            m_code  = err;
            m_pulse = 1;
            m_ec    = (m_ec < CMAX) ? m_ec + 1 : CMAX;
        end
    endtask

    task automatic check_all();
        check("tready",     s_axis_if.tready, m_tready);
        check("locked",     locked,     m_locked);
        check("lock_phase", lock_phase, m_phase);
        check("phase_ok",   phase_ok,   (m_locked != 0 && m_phase == PH) ? 1 : 0);
        check("frame_cnt",  frame_cnt,  m_fc);
        check("err_cnt",    err_cnt,    m_ec);
        check("err_pulse",  err_pulse,  m_pulse);
        check("err_code",   err_code,   m_code);
    endtask

    // Source drive: hold tvalid while a beat is pending, else random gap.
    task automatic drive(input bit hold);
        if (!hold) s_axis_if.tvalid = ($urandom_range(0, 9) < 8);
        s_axis_if.tdata = (src_ctr == src_phase && src_suppress == 0) ? W'(src_val) : '0;
    endtask

    task automatic cycle();
        bit mb, sb, c, e;
        int d;
        mb = s_axis_if.tvalid && (m_tready != 0);
        sb = s_axis_if.tvalid && s_axis_if.tready;
        d  = int'(s_axis_if.tdata);
        c  = clr;
        e  = en;
        @(posedge clk);
        #1;
        m_tready = (e && m_stall != S - 1) ? 1 : 0;
        m_stall  = (m_stall + 1) % S;
        model_step(c, mb, d);
        if (c) src_ctr = 0;
        else if (sb) begin
            src_ctr = (src_ctr + 1) % M;
            if (src_ctr == 0) src_frames++;
        end
        check_all();
        drive(s_axis_if.tvalid && !sb && !c);
    endtask

    task automatic run_frames(input int n);
        int target;
        target = src_frames + n;
        for (int k = 0; k < n * M * 4 && src_frames < target; k++) cycle();
        check("frame_budget", src_frames, target);
    endtask

    task automatic run_to(input int ctr);
        for (int k = 0; k < M * 4 && src_ctr != ctr; k++) cycle();
        check("position_budget", src_ctr, ctr);
    endtask

    initial begin
        rst = 1'b0; en = 1'b0; clr = 1'b0;
        s_axis_if.tvalid = 1'b0; s_axis_if.tdata = '0;
        src_ctr = 0; src_frames = 0; src_phase = PH; src_val = EXPV; src_suppress = 0;
        model_reset();
        m_tready = 0; m_stall = 0;
        #12;
        check("rst_tready", s_axis_if.tready, 0);
        check("rst_locked", locked, 0);
        check("rst_fcnt",   frame_cnt, 0);
        check("rst_code",   err_code, 0);

        // 1/2: nominal stream with periodic stalls, 8 frames
        @(negedge clk);
        rst = 1'b1; en = 1'b1;
        drive(1'b0);
        run_frames(8);
        check("t1_locked", locked, 1);
        check("t1_phase",  lock_phase, PH);
        check("t1_ok",     phase_ok, 1);
        check("t1_fcnt",   frame_cnt, 7);
        check("t1_ecnt",   err_cnt, 0);

        // en low mid-frame: position retained, checking resumes
        run_to(20);
        en = 1'b0;
        for (int k = 0; k < 20; k++) cycle();
        check("en_low_tready", s_axis_if.tready, 0);
        en = 1'b1;
        run_frames(2);
        check("en_fcnt", frame_cnt, 9);
        check("en_ecnt", err_cnt, 0);

        // 3: impulse moves to phase 10
        src_phase = 10;
        run_frames(1);
        check("t3_code",   err_code, 1);
        check("t3_ecnt",   err_cnt, 1);
        check("t3_phase",  lock_phase, 10);
        check("t3_ok",     phase_ok, 0);
        run_frames(2);
        check("t3_fcnt",   frame_cnt, 11);

        // 4: clear, relock at 49, then one suppressed impulse
        src_phase = PH;
        clr = 1'b1;
        cycle();
        clr = 1'b0;
        check("clr_fcnt", frame_cnt, 0);
        run_frames(2);
        check("t4_fcnt0", frame_cnt, 1);
        src_suppress = 1;
        run_frames(1);
        src_suppress = 0;
        check("t4_code",   err_code, 2);
        check("t4_locked", locked, 0);
        check("t4_ecnt",   err_cnt, 1);
        run_frames(1);
        check("t4_relock", locked, 1);
        check("t4_phase",  lock_phase, PH);
        check("t4_ecnt2",  err_cnt, 1);

        // 5: wrong impulse weight every frame; err_cnt saturates
        src_val = 3;
        run_frames(17);
        check("t5_code",   err_code, 3);
        check("t5_locked", locked, 1);
        check("t5_ecnt",   err_cnt, CMAX);
        check("t5_fcnt",   frame_cnt, 1);
        src_val = EXPV;
        run_frames(16);
        check("sat_fcnt",  frame_cnt, CMAX);
        check("sat_ecnt",  err_cnt, CMAX);

        // 6: asynchronous reset mid-frame at beat 30
        run_to(30);
        rst = 1'b0;
        #1;
        check("arst_tready", s_axis_if.tready, 0);
        check("arst_locked", locked, 0);
        check("arst_phase",  lock_phase, 0);
        check("arst_fcnt",   frame_cnt, 0);
        check("arst_ecnt",   err_cnt, 0);
        check("arst_code",   err_code, 0);
        model_reset();
        m_tready = 0; m_stall = 0; src_ctr = 0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        drive(1'b0);
        run_frames(2);
        check("t6_locked", locked, 1);
        check("t6_phase",  lock_phase, PH);
        check("t6_fcnt",   frame_cnt, 1);

        // clr coinciding with a beat mid-frame
        run_to(20);
        for (int k = 0; k < 10 && m_tready == 0; k++) cycle();
        check("clr_ready_budget", m_tready, 1);
        s_axis_if.tvalid = 1'b1;
        clr = 1'b1;
        cycle();
        clr = 1'b0;
        check("clrb_locked", locked, 0);
        check("clrb_pulse",  err_pulse, 0);
        check("clrb_ecnt",   err_cnt, 0);
        run_frames(2);
        check("clrb_relock", locked, 1);
        check("clrb_phase",  lock_phase, PH);
        check("clrb_ecnt2",  err_cnt, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
